// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - arbitrated front end sharing one 10-bit ripple-carry adder
//
// Purpose: up to NREQ requesters present operand pairs over valid/ready.
// One requester is granted at a time. Its operands are registered into a
// single adder10bit, and the 11-bit sum is returned tagged with the requester ID.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]      per-requester request valid
//   req_ready  [NREQ]      per-requester accept (one-hot or zero, combinational)
//   req_a      [NREQ*10]   operand A, requester i at [10i+9:10i]
//   req_b      [NREQ*10]   operand B, same packing
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_sum    [11]        registered sum {carry, sum[9:0]}
//   rsp_id     [IDW]       requester that produced rsp_sum
//   busy       high when not IDLE
//
// Build option: define ADD_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer). Default build is round-robin.

module adder10bit (
   input  logic [9:0]  a_i,
   input  logic [9:0]  b_i,
   input  logic        cin_i,
   output logic [10:0] sum_o
);
   logic [9:0] s;
   logic       c;

   always_comb begin
      s = '0;
      c = cin_i;
      for (int i = 0; i < 10; i++) begin
         s[i] = a_i[i] ^ b_i[i] ^ c;
         c    = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
   end

   assign sum_o = {c, s};
endmodule

module adder_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*10-1:0]   req_a,
   input  logic [NREQ*10-1:0]   req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [10:0]          rsp_sum,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy
);
   typedef enum logic [1:0] {S_IDLE, S_ADD, S_HOLD} state_t;

   state_t          state_q;
   logic [9:0]      a_q, b_q;
   logic [IDW-1:0]  id_q;
   logic            rsp_valid_q;
   logic [10:0]     rsp_sum_q;
   logic [IDW-1:0]  rsp_id_q;

   logic            any_req;
   logic [IDW-1:0]  gnt;
   logic            accept;
   logic [10:0]     sum;

`ifdef ADD_ARB_FIXED_PRIO_EN
   // Scan downward so the lowest asserted index is the last writer.
   always_comb begin
      any_req = 1'b0;
      gnt     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            any_req = 1'b1;
            gnt     = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0]  ptr_q;

   // Search starts at ptr_q and wraps; the first asserted request wins.
   always_comb begin
      int idx;
      any_req = 1'b0;
      gnt     = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!any_req && req_valid[idx]) begin
            any_req = 1'b1;
            gnt     = IDW'(idx);
         end
      end
   end
`endif

   // Reset masks the grant so no transfer happens on a reset cycle.
   assign accept    = (state_q == S_IDLE) && !rst && any_req;
   assign req_ready = accept ? (NREQ'(1) << gnt) : '0;

   adder10bit u_add (
      .a_i   (a_q),
      .b_i   (b_q),
      .cin_i (1'b0),
      .sum_o (sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= '0;
`ifndef ADD_ARB_FIXED_PRIO_EN
         ptr_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a_q     <= req_a[10*int'(gnt) +: 10];
                  b_q     <= req_b[10*int'(gnt) +: 10];
                  id_q    <= gnt;
                  state_q <= S_ADD;
`ifndef ADD_ARB_FIXED_PRIO_EN
                  ptr_q   <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
`endif
               end
            end
            S_ADD: begin
               rsp_sum_q   <= sum;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= S_HOLD;
            end
            S_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - directed self-checking bench for adder_share_arb

module tb_adder_share_arb;
   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [39:0] req_a;
   logic [39:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [10:0] rsp_sum;
   logic [1:0]  rsp_id;
   logic        busy;

   int total;
   int bad;

   adder_share_arb #(.NREQ(4), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [9:0] a, input logic [9:0] b);
      req_a[idx*10 +: 10] = a;
      req_b[idx*10 +: 10] = b;
   endtask

   // One isolated operation with rsp_ready held high.
   task automatic single_op(input int idx, input logic [9:0] a, input logic [9:0] b,
                            input logic [10:0] exp_sum);
      set_req(idx, a, b);
      req_valid = 4'(1 << idx);
      #1;
      chk("single_rdy", 32'(req_ready), 32'(1 << idx));
      chk("single_busy_idle", 32'(busy), 0);
      step();
      req_valid = '0;
      #1;
      chk("single_busy_add", 32'(busy), 1);
      chk("single_vld_add", 32'(rsp_valid), 0);
      step();
      #1;
      chk("single_vld", 32'(rsp_valid), 1);
      chk("single_sum", 32'(rsp_sum), 32'(exp_sum));
      chk("single_id", 32'(rsp_id), 32'(idx));
      chk("single_busy_hold", 32'(busy), 1);
      step();
      #1;
      chk("single_back_idle", 32'(busy), 0);
      chk("single_vld_clr", 32'(rsp_valid), 0);
   endtask

   initial begin
      int exp_g;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset with requests present: no accept, outputs at reset values.
      step();
      #1;
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_vld", 32'(rsp_valid), 0);
      chk("rst_sum", 32'(rsp_sum), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      step();
      rst       = 1'b0;
      req_valid = '0;

      single_op(2, 10'd300, 10'd200, 11'd500);
      single_op(3, 10'd1023, 10'd1023, 11'd2046);
      single_op(0, 10'd0, 10'd0, 11'd0);

      // Backpressure on requester 1 while requester 3 arrives mid-wait.
      rsp_ready = 1'b0;
      set_req(1, 10'd5, 10'd6);
      req_valid = 4'b0010;
      #1;
      chk("bp_rdy1", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      step();
      set_req(3, 10'd17, 10'd25);
      req_valid = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_vld", 32'(rsp_valid), 1);
         chk("bp_sum", 32'(rsp_sum), 11);
         chk("bp_id", 32'(rsp_id), 1);
         chk("bp_rdy", 32'(req_ready), 0);
         chk("bp_busy", 32'(busy), 1);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_vld_last", 32'(rsp_valid), 1);
      step();
      #1;
      chk("mw_rdy3", 32'(req_ready), 32'h8);
      chk("mw_idle", 32'(busy), 0);
      step();
      req_valid = '0;
      step();
      #1;
      chk("mw_vld", 32'(rsp_valid), 1);
      chk("mw_sum", 32'(rsp_sum), 42);
      chk("mw_id", 32'(rsp_id), 3);
      step();

      // Reset during ADD: result discarded, pointer back to 0.
      set_req(2, 10'd111, 10'd222);
      req_valid = 4'b0100;
      #1;
      chk("rm_rdy2", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rm_vld", 32'(rsp_valid), 0);
      chk("rm_sum", 32'(rsp_sum), 0);
      chk("rm_id", 32'(rsp_id), 0);
      chk("rm_busy", 32'(busy), 0);
      chk("rm_rdy", 32'(req_ready), 0);
      step();
      #1;
      chk("rm_still_idle", 32'(rsp_valid), 0);

      // All four held valid: grant sequence, one response per 3 cycles.
      for (int i = 0; i < 4; i++) set_req(i, 10'(100*i + 7), 10'(50*i + 3));
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = k % 4;
`endif
         #1;
         chk("rr_rdy", 32'(req_ready), 32'(1 << exp_g));
         chk("rr_idle_vld", 32'(rsp_valid), 0);
         step();
         chk("rr_add_vld", 32'(rsp_valid), 0);
         chk("rr_add_busy", 32'(busy), 1);
         step();
         chk("rr_hold_vld", 32'(rsp_valid), 1);
         chk("rr_hold_id", 32'(rsp_id), 32'(exp_g));
         chk("rr_hold_sum", 32'(rsp_sum), 32'(150*exp_g + 10));
         step();
      end
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Arbitrated front end for the shared 10-bit ripple-carry adder (`adder10bit`). Up to `NREQ` requesters each present an operand pair with a valid/ready handshake. The block grants one requester at a time and registers the operands into a single internal `adder10bit` instance. It returns the registered 11-bit sum tagged with the requester ID over a valid/ready response channel, so one adder serves several datapath clients.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `IDW`, 2: requester ID width; must equal ceil(log2(`NREQ`)).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input `NREQ`: per-requester request valid.
- `req_ready` output `NREQ`: per-requester accept; at most one bit high in any cycle.
- `req_a` input `NREQ*10`: operand A; requester i uses bits [10i+9:10i].
- `req_b` input `NREQ*10`: operand B; same packing as `req_a`.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_sum` output 11: registered sum {carry, sum[9:0]}.
- `rsp_id` output `IDW`: index of the requester that produced `rsp_sum`.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: selects a grant g among asserted `req_valid`. If any request is present, drives `req_ready[g]`=1, latches `a_q`, `b_q`, `id_q`=g, and moves to ADD.
  - ADD: the internal `adder10bit` evaluates `a_q`+`b_q` with carry-in 0. Latches `rsp_sum`, `rsp_id`=`id_q`, sets `rsp_valid`=1, and moves to HOLD.
  - HOLD: holds `rsp_valid`, `rsp_sum` and `rsp_id` stable. On `rsp_valid && rsp_ready`, clears `rsp_valid` and returns to IDLE.
- `req_ready` is combinational: asserted only in IDLE, and only for the granted index. It may depend on same-cycle `req_valid`.
- A request transfers on `req_valid[i] && req_ready[i]`. A requester holds `req_valid` and its operands stable until that transfer; the block never drops an accepted request.
- Default arbitration is round-robin:
  - Pointer `ptr` resets to 0.
  - The search runs `ptr`, `ptr+1`, … mod `NREQ`; the first asserted request wins.
  - After granting g, `ptr` becomes (g+1) mod `NREQ`.
  - `ptr` does not change when no grant occurs.
- Arithmetic: unsigned 10-bit + 10-bit into 11 bits; no overflow is possible. Maximum result is 1023+1023=2046 (`rsp_sum`=11'h7FE).
- No request is accepted while in ADD or HOLD. Outstanding requests wait, and arbitration is re-evaluated on return to IDLE.
- Reset values:
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `req_ready`=0, `busy`=0.
  - State=IDLE, `ptr`=0, `a_q`=`b_q`=`id_q`=0.
- Reset in any state, including mid-ADD or HOLD: the in-flight result is discarded, outputs return to reset values on the next edge, and no response is emitted.

## Timing
- Cycle N (IDLE): handshake and grant.
- Cycle N+1 (ADD): add.
- Edge ending N+1: `rsp_valid` rises and is visible from cycle N+2.
- Latency is 2 cycles from request accept to first `rsp_valid`.
- Minimum occupancy is 3 cycles per operation (IDLE, ADD, HOLD with `rsp_ready`=1). Peak throughput is one sum per 3 cycles.
- `rsp_ready` held low stretches HOLD indefinitely; outputs stay stable throughout.
- `busy`=1 exactly in ADD and HOLD.
- `rst` asserted together with `req_valid` in IDLE: no `req_ready` is driven and no accept occurs.

## Configuration
- `ADD_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest asserted index always wins, and `ptr` is not implemented.
  - Undefined (default): round-robin as described above.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Single request: req 2 with a=10'd300, b=10'd200, `rsp_ready`=1. Expect `req_ready[2]` in cycle N; `rsp_valid` in N+2 with `rsp_sum`=11'd500 and `rsp_id`=2; `busy`=1 in N+1..N+2.
- Max operands: a=b=10'd1023 → `rsp_sum`=11'd2046 (carry bit 1). Zero operands: a=b=0 → `rsp_sum`=0.
- All four requesters held valid continuously from reset, `rsp_ready`=1:
  - Round-robin build: grant order 0,1,2,3,0, each response 3 cycles apart.
  - Fixed-priority build (`ADD_ARB_FIXED_PRIO_EN`): requester 0 wins every time.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`. Expect `rsp_valid`, `rsp_sum` and `rsp_id` stable and `req_ready` all 0 throughout; IDLE is re-entered one cycle after `rsp_ready` rises.
- Reset mid-operation: assert `rst` for 1 cycle during ADD. Expect no `rsp_valid`, all outputs at reset values, and `ptr`=0 (next grant goes to requester 0).
- Mid-wait arrival: requester 3 asserts valid while requester 1 is in HOLD. Expect requester 3 to be granted in the first IDLE cycle after the requester 1 response handshake, with its operands unchanged in the result.
